// File: rtl/cpld_row_sequencer_pkg.sv
// cpld_pkg: shared types and constants for the CPLD3 row sequencer.
//   state_t   - sequencer FSM states
//   ROW_W     - row word width (left_in2, right_out2)
//   SEL_OUT_W - datapath select echo width
//   POS_W     - column index width (pos_c)
//   OUT_W     - captured result width {sel_out2, right_out2}
//   WD_LIMIT  - watchdog abort threshold (CPLD_SEQ_TIMEOUT_EN builds)
package cpld_pkg;
  localparam int ROW_W     = 5;
  localparam int SEL_OUT_W = 4;
  localparam int POS_W     = 3;
  localparam int OUT_W     = ROW_W + SEL_OUT_W;
  localparam logic [7:0] WD_LIMIT = 8'd255;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    SWEEP   = 3'd2,
    CAPTURE = 3'd3,
    OUT     = 3'd4,
    DONE    = 3'd5
  } state_t;
endpackage

// File: rtl/cpld_row_sequencer_if.sv
// cpld_row_sequencer_if: upstream word stream and downstream result stream.
//   in_data/in_valid/in_ready    - row words into the sequencer
//   out_data/out_valid/out_ready - captured results out of the sequencer
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1; the sender holds data/valid stable until that edge.
// Modports: master = environment (word source + result sink), slave = sequencer.
interface cpld_row_sequencer_if;
  import cpld_pkg::*;

  logic [ROW_W-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (output in_data, in_valid, out_ready,
                  input  in_ready, out_data, out_valid);
  modport slave  (input  in_data, in_valid, out_ready,
                  output in_ready, out_data, out_valid);
endinterface

// File: rtl/cpld_col_stepper.sv
// cpld_col_stepper: column position counter plus one-hot select shifter.
//   clk, rst - clock, async active-high reset
//   load     - pos <= 0, sel <= one-hot bit 0
//   step     - pos <= pos + 1, sel shifts left one place
//   clear    - sel <= 0 (pos is kept)
//   pos      - column index
//   sel      - one-hot of pos while sweeping
//   last     - pos is the final column (NUM_COLS-1)
module cpld_col_stepper
  import cpld_pkg::*;
#(
  parameter int NUM_COLS = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                step,
  input  logic                clear,
  output logic [POS_W-1:0]    pos,
  output logic [NUM_COLS-1:0] sel,
  output logic                last
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos <= '0;
      sel <= '0;
    end else if (load) begin
      pos <= '0;
      sel <= {{(NUM_COLS-1){1'b0}}, 1'b1};
    end else if (step) begin
      pos <= pos + 1'b1;
      sel <= {sel[NUM_COLS-2:0], 1'b0};
    end else if (clear) begin
      sel <= '0;
    end
  end

  assign last = (pos == POS_W'(NUM_COLS - 1));
endmodule

// File: rtl/cpld_row_sequencer.sv
// cpld_row_sequencer: sequences the CPLD3 row datapath. Per row it fetches a
// word, sweeps pos_c/sel over NUM_COLS columns, captures {sel_out2,right_out2}
// and hands it downstream; repeats num_rows times or until last_row.
// Ports:
//   clk, rst        - clock, async active-high reset
//   start, num_rows - job start pulse and row count (0 = empty job)
//   stream          - slave side of in_*/out_* handshakes
//   left_in2, sel, pos_c          - registered datapath drive
//   right_out2, sel_out2, last_row - datapath results
//   busy, done, early_stop        - job status
//   timeout         - watchdog abort flag (only with CPLD_SEQ_TIMEOUT_EN)
//   dbg_state       - current FSM state
// Optional build macro: CPLD_SEQ_TIMEOUT_EN adds a 255-cycle stall watchdog.
module cpld_row_sequencer
  import cpld_pkg::*;
#(
  parameter int NUM_COLS  = 5,
  parameter int ROW_CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ROW_CNT_W-1:0] num_rows,
  cpld_row_sequencer_if.slave  stream,
  output logic [ROW_W-1:0]     left_in2,
  output logic [NUM_COLS-1:0]  sel,
  output logic [POS_W-1:0]     pos_c,
  input  logic [ROW_W-1:0]     right_out2,
  input  logic [SEL_OUT_W-1:0] sel_out2,
  input  logic                 last_row,
  output logic                 busy,
  output logic                 done,
  output logic                 early_stop,
`ifdef CPLD_SEQ_TIMEOUT_EN
  output logic                 timeout,
`endif
  output state_t               dbg_state
);
  state_t state, state_nxt;
  logic load, step, clear, last, wd_expire;
  logic is_final;
  logic [ROW_CNT_W-1:0] num_rows_q, row_cnt, row_nxt;

  assign row_nxt = row_cnt + 1'b1;

  cpld_col_stepper #(.NUM_COLS(NUM_COLS)) u_stepper (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .clear(clear),
    .pos  (pos_c),
    .sel  (sel),
    .last (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    clear     = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = (num_rows == '0) ? DONE : FETCH;
      FETCH:   if (stream.in_valid) begin
                 load      = 1'b1;
                 state_nxt = SWEEP;
               end
      // The final column holds for one cycle so SWEEP spans NUM_COLS cycles.
      SWEEP:   if (last) state_nxt = CAPTURE;
               else      step      = 1'b1;
      CAPTURE: begin
                 clear     = 1'b1;
                 state_nxt = OUT;
               end
      // out_valid is always 1 in OUT, so out_ready alone completes the transfer.
      OUT:     if (stream.out_ready) state_nxt = is_final ? DONE : FETCH;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (wd_expire) state_nxt = DONE;
  end

  assign stream.in_ready = (state == FETCH);
  assign done            = (state == DONE);
  assign dbg_state       = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_in2         <= '0;
      stream.out_data  <= '0;
      stream.out_valid <= 1'b0;
      num_rows_q       <= '0;
      row_cnt          <= '0;
      is_final         <= 1'b0;
      busy             <= 1'b0;
      early_stop       <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        num_rows_q <= num_rows;
        row_cnt    <= '0;
        early_stop <= 1'b0;
        busy       <= 1'b1;
      end
      if (load) left_in2 <= stream.in_data;
      if (state == CAPTURE) begin
        stream.out_data  <= {sel_out2, right_out2};
        stream.out_valid <= 1'b1;
        row_cnt          <= row_nxt;
        is_final         <= last_row | (row_nxt == num_rows_q);
        early_stop       <= last_row & (row_nxt != num_rows_q);
      end
      if (state == OUT && stream.out_ready) stream.out_valid <= 1'b0;
      if (wd_expire) stream.out_valid <= 1'b0;
      if (state == DONE) busy <= 1'b0;
    end
  end

`ifdef CPLD_SEQ_TIMEOUT_EN
  // One counter serves both waits: FETCH and OUT never overlap, and leaving
  // either wait condition restarts the count.
  logic [7:0] wd;
  logic       wd_idle;

  assign wd_idle   = (state == FETCH && !stream.in_valid) ||
                     (state == OUT && !stream.out_ready);
  assign wd_expire = wd_idle && (wd == WD_LIMIT - 8'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd      <= '0;
      timeout <= 1'b0;
    end else begin
      wd <= wd_idle ? wd + 8'd1 : 8'd0;
      if (state == IDLE && start) timeout <= 1'b0;
      else if (wd_expire)         timeout <= 1'b1;
    end
  end
`else
  assign wd_expire = 1'b0;
`endif
endmodule

// File: tb/tb_cpld_row_sequencer.sv
// tb_cpld_row_sequencer: directed plus randomized jobs against a row-level
// reference model (expected result queue built from the words sent).
module tb_cpld_row_sequencer;
  import cpld_pkg::*;

  localparam int NUM_COLS  = 5;
  localparam int ROW_CNT_W = 3;

  logic clk, rst, start, last_row;
  logic [ROW_CNT_W-1:0] num_rows;
  logic [ROW_W-1:0] left_in2, right_out2;
  logic [NUM_COLS-1:0] sel;
  logic [POS_W-1:0] pos_c;
  logic [SEL_OUT_W-1:0] sel_out2;
  logic busy, done, early_stop;
  state_t dbg_state;
`ifdef CPLD_SEQ_TIMEOUT_EN
  logic timeout;
`endif

  cpld_row_sequencer_if io();

  cpld_row_sequencer #(.NUM_COLS(NUM_COLS), .ROW_CNT_W(ROW_CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
    .stream(io),
    .left_in2(left_in2), .sel(sel), .pos_c(pos_c),
    .right_out2(right_out2), .sel_out2(sel_out2), .last_row(last_row),
    .busy(busy), .done(done), .early_stop(early_stop),
`ifdef CPLD_SEQ_TIMEOUT_EN
    .timeout(timeout),
`endif
    .dbg_state(dbg_state)
  );

  // Datapath stand-in: result is a fixed function of the row word.
  assign right_out2 = ~left_in2;
  assign sel_out2   = left_in2[3:0] ^ 4'h5;

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [OUT_W-1:0] exp_q[$];
  logic [ROW_W-1:0] word_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_left"}, left_in2, 0);
    chk({tag, "_sel"}, sel, 0);
    chk({tag, "_pos"}, pos_c, 0);
    chk({tag, "_ov"}, io.out_valid, 0);
    chk({tag, "_od"}, io.out_data, 0);
    chk({tag, "_ir"}, io.in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_early"}, early_stop, 0);
    chk({tag, "_state"}, dbg_state, IDLE);
  endtask

  // Runs one job; stop_row is the row index with last_row high (>= n: none).
  task automatic run_job(input int n, input int stop_row, input int ready_gap,
                         input int valid_gap, input int stall_len, input bit poke_start);
    int acc, res, since_acc, rows_exp, stall;
    bit done_seen, hs_last, final_hs, waiting_rise, early_exp;
    logic [ROW_W-1:0] w, cur_w;
    rows_exp  = (n == 0) ? 0 : ((stop_row < n) ? stop_row + 1 : n);
    early_exp = (stop_row < n - 1);
    exp_q.delete();
    start = 1'b1; num_rows = ROW_CNT_W'(n);
    io.in_valid = 1'b0; io.out_ready = 1'b0; last_row = 1'b0;
    tick();
    start = 1'b0;
    chk("busy_on_start", busy, 1);
    chk("early_clr_on_start", early_stop, 0);
`ifdef CPLD_SEQ_TIMEOUT_EN
    chk("timeout_clr_on_start", timeout, 0);
`endif
    acc = 0; res = 0; since_acc = 1000; stall = 0; cur_w = '0;
    done_seen = 1'b0; hs_last = 1'b0; final_hs = (n == 0); waiting_rise = 1'b0;
    for (int cyc = 0; cyc < 3000 && !done_seen; cyc++) begin
      if (hs_last) chk("ov_drop_after_hs", io.out_valid, 0);
      if (done) begin
        done_seen = 1'b1;
        chk("done_follows_final", final_hs, 1);
        chk("rows_fetched", acc, rows_exp);
        chk("rows_out", res, rows_exp);
        chk("busy_at_done", busy, 1);
        chk("early_stop", early_stop, early_exp);
      end
      hs_last = 1'b0; final_hs = 1'b0;
      if (since_acc < NUM_COLS) begin
        chk("sweep_pos", pos_c, since_acc);
        chk("sweep_sel", sel, 1 << since_acc);
        chk("left_in2", left_in2, cur_w);
        chk("in_ready_sweep", io.in_ready, 0);
        chk("ov_sweep", io.out_valid, 0);
      end
      if (io.out_valid) begin
        if (waiting_rise) begin
          chk("latency", since_acc, NUM_COLS + 1);
          waiting_rise = 1'b0;
        end
        chk("in_ready_out", io.in_ready, 0);
        chk("sel_idle_out", sel, 0);
        if (exp_q.size() == 0) chk("spurious_out", io.out_valid, 0);
        else                   chk("out_data", io.out_data, exp_q[0]);
      end
      // drive next edge
      start       = poke_start && (since_acc == 2);
      io.in_data  = ROW_W'($urandom);
      io.in_valid = ($urandom_range(0, valid_gap) == 0);
      last_row    = (acc > 0) && (acc - 1 == stop_row);
      if (io.in_ready && io.in_valid) begin
        if (word_q.size() > 0) io.in_data = word_q.pop_front();
        w = io.in_data;
        exp_q.push_back({w[3:0] ^ 4'h5, ~w});
        acc++; cur_w = w; since_acc = -1; waiting_rise = 1'b1;
        last_row = (acc - 1 == stop_row);
      end else if (io.in_ready && stop_row >= n) begin
        last_row = 1'($urandom);
      end
      if (io.out_valid && stall < stall_len) begin
        io.out_ready = 1'b0;
        stall++;
      end else begin
        io.out_ready = ($urandom_range(0, ready_gap) == 0);
      end
      if (io.out_valid && io.out_ready) begin
        res++; hs_last = 1'b1; final_hs = (res == rows_exp);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      tick();
      since_acc++;
    end
    start = 1'b0; io.in_valid = 1'b0; io.out_ready = 1'b0; last_row = 1'b0;
    chk("done_seen", done_seen, 1);
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
    chk("state_idle", dbg_state, IDLE);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int got;
    bit seen;
    rst = 1'b1; start = 1'b0; num_rows = '0; last_row = 1'b0;
    io.in_data = '0; io.in_valid = 1'b0; io.out_ready = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset_held");
    rst = 1'b0;
    tick();
    chk_all_zero("reset_released");

    // Empty job, then the two-word directed job.
    run_job(0, 99, 0, 0, 0, 1'b0);
    word_q.push_back(5'h15);
    word_q.push_back(5'h0A);
    run_job(2, 99, 0, 0, 0, 1'b0);
    // Early stop on row 2 of 4; last_row on the genuine final row.
    run_job(4, 1, 0, 0, 0, 1'b0);
    run_job(3, 2, 1, 1, 0, 1'b0);
    // Ten-cycle downstream stall, start poked mid-sweep, maximum job size.
    run_job(3, 99, 0, 0, 10, 1'b0);
    run_job(3, 99, 1, 1, 0, 1'b1);
    run_job(7, 99, 2, 2, 0, 1'b0);
    for (int j = 0; j < 8; j++) begin
      run_job($urandom_range(0, 7), $urandom_range(0, 9), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 4), 1'($urandom));
    end

    // Reset in the middle of a sweep.
    start = 1'b1; num_rows = 3'd3;
    tick();
    start = 1'b0; io.in_valid = 1'b1; io.in_data = 5'h13;
    tick();
    io.in_valid = 1'b0;
    tick();
    tick();
    chk("pre_reset_pos", pos_c, 2);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("async_reset");
    seen = 1'b0;
    repeat (3) begin
      tick();
      if (done) seen = 1'b1;
    end
    rst = 1'b0;
    tick();
    chk("no_done_after_reset", seen, 0);
    chk_all_zero("after_mid_reset");

    // Upstream starves in FETCH.
    start = 1'b1; num_rows = 3'd1; io.in_valid = 1'b0;
    tick();
    start = 1'b0;
`ifdef CPLD_SEQ_TIMEOUT_EN
    got = -1;
    for (int k = 0; k < 300; k++) begin
      if (done) begin
        got = k;
        break;
      end
      tick();
    end
    chk("timeout_done_cycle", got, 255);
    chk("timeout_flag", timeout, 1);
    chk("timeout_ov", io.out_valid, 0);
    tick();
    chk("timeout_idle", dbg_state, IDLE);
    chk("timeout_busy", busy, 0);
    chk("timeout_held", timeout, 1);
`else
    got = 0;
    repeat (300) begin
      if (done) got++;
      tick();
    end
    chk("starve_no_done", got, 0);
    chk("starve_state", dbg_state, FETCH);
    chk("starve_in_ready", io.in_ready, 1);
    chk("starve_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
`endif
    run_job(1, 99, 0, 0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cpld_row_sequencer.md
Name: cpld_row_sequencer

Overview:
- Controller that sequences the CPLD3 row datapath: fetches one 5-bit row word from upstream, sweeps the column position/select across NUM_COLS cycles, then captures the datapath result and hands it downstream.
- Repeats for a programmed number of rows, stopping early if the datapath raises last_row.
- Sits between the row-word source and the CPLD3 instance; it is the only driver of left_in2, sel and pos_c.

Parameters:
- NUM_COLS, 5, columns swept per row (2..5); bounds pos_c and the one-hot width of sel.
- ROW_CNT_W, 3, width of the row count and of num_rows.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a job when idle
- num_rows  in  ROW_CNT_W  rows in the job, sampled on an accepted start; 0 = empty job
- in_data  in  5  upstream row word
- in_valid  in  1  upstream word valid
- in_ready  out  1  sequencer can accept a word
- left_in2  out  5  row word to datapath, registered
- sel  out  5  one-hot column select to datapath, registered
- pos_c  out  3  column index to datapath, registered
- right_out2  in  5  datapath row result
- sel_out2  in  4  datapath select echo
- last_row  in  1  datapath end-of-data flag
- out_data  out  9  {sel_out2, right_out2} captured result
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end
- early_stop  out  1  job ended by last_row; held until the next accepted start

Behaviour:
- Reset: every output is 0 (sel = 5'b00000, pos_c = 0, out_valid = 0, in_ready = 0); state is IDLE; row counter is 0.
- IDLE:
  - start = 1 latches num_rows, clears early_stop and the row counter, and sets busy.
  - num_rows = 0: go to DONE. Otherwise go to FETCH.
  - start while busy is ignored.
- FETCH:
  - in_ready = 1.
  - On in_valid & in_ready: left_in2 <= in_data, pos_c <= 0, sel <= 5'b00001; go to SWEEP.
- SWEEP:
  - Each cycle: pos_c increments and sel shifts left by one. sel is always one-hot of pos_c.
  - In the cycle where pos_c = NUM_COLS-1, go to CAPTURE. SWEEP therefore lasts NUM_COLS cycles.
  - left_in2 is held stable throughout.
- CAPTURE (1 cycle):
  - out_data <= {sel_out2, right_out2}; out_valid <= 1; row counter increments.
  - Records final = last_row | (row counter + 1 == num_rows).
  - early_stop <= last_row & (row counter + 1 != num_rows).
  - sel <= 0. Go to OUT.
- OUT:
  - out_valid and out_data are held stable until out_ready.
  - On out_valid & out_ready: out_valid <= 0, then go to DONE if final, else FETCH.
  - No new row word is fetched while a result is pending.
- DONE: done = 1 for exactly one cycle; busy <= 0; go to IDLE.
- Latency: from the word accept edge to out_valid rising is NUM_COLS + 1 cycles.
- last_row is sampled only in CAPTURE; it is ignored in every other state.
- Counter wrap: the row counter is ROW_CNT_W bits. num_rows = 2^ROW_CNT_W - 1 is the maximum job size; the counter never wraps within a job.
- Reset mid-job: the asynchronous return to the reset values above. No done pulse, and any pending result is discarded.

Optional Feature:
- Macro: CPLD_SEQ_TIMEOUT_EN.
- Defined:
  - An 8-bit watchdog counts consecutive FETCH cycles with in_valid = 0, and separately consecutive OUT cycles with out_ready = 0.
  - At 255 the job aborts: out_valid <= 0, then done pulses.
  - Adds output timeout (1 bit), set with the abort and cleared on the next accepted start.
- Not defined: no watchdog and no timeout port; the sequencer waits indefinitely.

Decomposition:
- Shared package cpld_pkg:
  - State enum: IDLE, FETCH, SWEEP, CAPTURE, OUT, DONE.
  - Constants ROW_W = 5, SEL_OUT_W = 4, POS_W = 3.
  - Watchdog limit constant 255.
- One natural sub-module: cpld_col_stepper, holding the pos_c counter plus the sel one-hot shifter, with load, step and last outputs.

Test Plan:
- Reset held, then released -> all outputs 0 and state IDLE; start with num_rows = 0 -> done pulses 1 cycle after start, busy high only for that cycle.
- num_rows = 2, words 5'h15 and 5'h0A with in_valid always high, out_ready = 1 -> sel walks 01, 02, 04, 08, 10 and pos_c 0..4 per row; 2 results; out_valid rises 6 cycles after each accept; done after the 2nd handshake.
- num_rows = 4, last_row = 1 during the 2nd CAPTURE -> exactly 2 results, done pulses, early_stop = 1.
- out_ready held low 10 cycles in OUT -> out_data stable, in_ready = 0, no sweep activity; result transfers on the cycle out_ready rises.
- start pulsed during SWEEP -> ignored, job count unchanged; rst asserted mid-SWEEP -> outputs 0 immediately (asynchronous), no done pulse.
- CPLD_SEQ_TIMEOUT_EN defined, in_valid low 255 cycles in FETCH -> timeout = 1, done pulses; not defined -> sequencer still in FETCH.
